shift_add_mult_4bit: RTL and testbench



---
 rtl/shift_add_mult_4bit.sv | 112 +++++++++++
 tb/tb_shift_add_mult_4bit.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/shift_add_mult_4bit.sv
// Sequential unsigned shift-add multiplier: one add step and one shift step per multiplier bit.
// The {C,A,Q} register chain ends up holding the 2N-bit product in {A,Q}.
module shift_add_mult_4bit #(
   parameter int N = 4
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           start,
   input  logic [N-1:0]   a,
   input  logic [N-1:0]   b,
   output logic           busy,
   output logic           done,
   output logic [2*N-1:0] product
);

   localparam int CW = $clog2(N) + 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ADD,
      S_SHIFT,
      S_DONE
   } state_t;

   state_t           state_q, state_d;
   logic [N-1:0]     m_q, m_d;
   logic [N-1:0]     acc_q, acc_d;
   logic             c_q, c_d;
   logic [N-1:0]     q_q, q_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [2*N-1:0]   product_q, product_d;

   logic [N:0]       sum;
   logic [2*N:0]     shifted;

   assign sum     = {1'b0, acc_q} + {1'b0, m_q};
   assign shifted = {c_q, acc_q, q_q} >> 1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         m_q       <= '0;
         acc_q     <= '0;
         c_q       <= 1'b0;
         q_q       <= '0;
         cnt_q     <= '0;
         product_q <= '0;
      end else begin
         state_q   <= state_d;
         m_q       <= m_d;
         acc_q     <= acc_d;
         c_q       <= c_d;
         q_q       <= q_d;
         cnt_q     <= cnt_d;
         product_q <= product_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      m_d       = m_q;
      acc_d     = acc_q;
      c_d       = c_q;
      q_d       = q_q;
      cnt_d     = cnt_q;
      product_d = product_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               m_d     = a;
               q_d     = b;
               acc_d   = '0;
               c_d     = 1'b0;
               cnt_d   = CW'(N);
               state_d = S_ADD;
            end
         end
         S_ADD: begin
            if (q_q[0]) begin
               {c_d, acc_d} = sum;
            end else begin
               c_d = 1'b0;
            end
            state_d = S_SHIFT;
         end
         S_SHIFT: begin
            {c_d, acc_d, q_d} = shifted;
            cnt_d             = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
               // Capture the post-shift value so the product is visible during DONE.
               product_d = shifted[2*N-1:0];
               state_d   = S_DONE;
            end else begin
               state_d = S_ADD;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_comb begin
      busy    = (state_q != S_IDLE);
      done    = (state_q == S_DONE);
      product = product_q;
   end

endmodule

// File: tb/tb_shift_add_mult_4bit.sv
// Self-checking bench for shift_add_mult_4bit: directed cases plus random operands
// checked against a plain a*b reference and the expected fixed latency.
module tb_shift_add_mult_4bit;

   localparam int N   = 4;
   localparam int LAT = 2*N + 1;  // negedges after the accepting edge until done is seen

   logic           clk   = 1'b0;
   logic           rst_n = 1'b0;
   logic           start = 1'b0;
   logic [N-1:0]   a     = '0;
   logic [N-1:0]   b     = '0;
   logic           busy;
   logic           done;
   logic [2*N-1:0] product;

   int             errors = 0;
   int             checks = 0;
   logic [2*N-1:0] model_prod = '0;

   shift_add_mult_4bit #(.N(N)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start),
      .a       (a),
      .b       (b),
      .busy    (busy),
      .done    (done),
      .product (product)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Starts a multiply, optionally pulses a stray start (a=2,b=2) at cycles p1/p2,
   // and returns at the negedge of the first IDLE cycle after done.
   task automatic run_mult(input logic [N-1:0] ta, input logic [N-1:0] tb,
                           input int p1, input int p2);
      int             cyc;
      bit             seen;
      logic [2*N-1:0] exp_p;
      exp_p = (2*N)'(ta) * (2*N)'(tb);
      start = 1'b1;
      a     = ta;
      b     = tb;
      @(posedge clk);
      #1;
      start = 1'b0;
      a     = N'($urandom);
      b     = N'($urandom);
      cyc   = 0;
      seen  = 1'b0;
      while (!seen && cyc < 40) begin
         @(negedge clk);
         cyc++;
         if (done) begin
            seen = 1'b1;
         end else begin
            check("busy_run", busy, 1);
            check("hold_product", product, model_prod);
         end
         start = (cyc == p1 || cyc == p2);
         if (start) begin
            a = N'(2);
            b = N'(2);
         end
      end
      check("done_seen", seen, 1);
      check("latency", cyc, LAT);
      check("product", product, exp_p);
      check("busy_done", busy, 1);
      model_prod = exp_p;
      $display("mult a=%h b=%h -> product=%h expected=%h after %0d cycles", ta, tb, product, exp_p, cyc + 1);
      @(negedge clk);
      start = 1'b0;
      check("done_width", done, 0);
      check("idle_busy", busy, 0);
      check("product_hold", product, model_prod);
   endtask

   initial begin
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_product", product, 0);
      rst_n = 1'b1;
      repeat (4) begin
         @(negedge clk);
         check("idle_busy0", busy, 0);
         check("idle_done0", done, 0);
         check("idle_product0", product, 0);
      end
      $display("reset then idle: busy=%b done=%b product=%h", busy, done, product);

      run_mult(4'h5, 4'h3, 0, 0);
      run_mult(4'hF, 4'hF, 0, 0);
      run_mult(4'h0, 4'hA, 0, 0);
      run_mult(4'h1, 4'hF, 0, 0);
      run_mult(4'h7, 4'h6, 3, LAT);
      repeat (3) begin
         @(negedge clk);
         check("no_second_op", busy, 0);
      end

      // Asynchronous reset between clock edges in the middle of an operation.
      start = 1'b1;
      a     = 4'hC;
      b     = 4'hB;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (5) @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("midrst_busy", busy, 0);
      check("midrst_done", done, 0);
      check("midrst_product", product, 0);
      model_prod = '0;
      $display("reset mid-operation: busy=%b done=%b product=%h", busy, done, product);
      @(negedge clk);
      check("midrst_hold_done", done, 0);
      rst_n = 1'b1;
      run_mult(4'hC, 4'hB, 0, 0);

      // Back-to-back: start on the first IDLE cycle after done.
      run_mult(4'h9, 4'h9, 0, 0);

      for (int i = 0; i < 12; i++) begin
         int gap;
         gap = int'($urandom_range(0, 2));
         repeat (gap) @(negedge clk);
         run_mult(N'($urandom), N'($urandom), 0, 0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
